// File: rtl/display_mux_ctrl_pkg.sv
// display_mux_ctrl_pkg
//   Shared constants for the two-digit multiplexed 7-segment display
//   controller: FSM state encoding, active-low digit enables, the blank
//   pattern and the hex-to-segment lookup table.
//   Segment bit order is bit6=g ... bit0=a, all active-low.
package display_mux_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG0 = 2'd1,
        DIG1 = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_DIG0 = 2'b10;
    localparam logic [1:0] AN_DIG1 = 2'b01;

    // Index 0 is the rightmost element, so the list runs F down to 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/display_mux_ctrl_hex.sv
// hex_to_seg7
//   Purely combinational nibble to active-low 7-segment decoder.
//   Ports:
//     hex  in  4  nibble to decode
//     seg  out 7  active-low segments, bit6=g ... bit0=a
module hex_to_seg7
    import display_mux_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/display_mux_ctrl.sv
// display_mux_ctrl
//   Captures a byte from the processor write-back path and scans it onto a
//   two-digit common-bus 7-segment display. Each digit is held for
//   REFRESH_DIV clock cycles. Scanning starts on the first capture after
//   reset and is never re-phased by later writes.
//   Ports:
//     clk      in  1  system clock, rising edge
//     rst_n    in  1  asynchronous active-low reset
//     wr_en    in  1  capture strobe
//     wr_data  in  8  value to display, sampled when wr_en=1
//     seg      out 7  shared segment bus, active-low, registered
//     an       out 2  digit enables, active-low, registered (an[0]=low nibble)
//     valid    out 1  high once any value has been captured since reset
module display_mux_ctrl
    import display_mux_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       valid
);

    localparam int              CNT_W  = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(REFRESH_DIV - 1);

    state_t           state;
    logic [7:0]       cap;
    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic [3:0]       nib;
    logic [6:0]       hex_seg;
    logic             blank_hi;

    assign tc = (cnt == CNT_TC);

    // One decoder shared by both digits; the state picks the nibble.
    assign nib = (state == DIG1) ? cap[7:4] : cap[3:0];

    hex_to_seg7 u_hex (
        .hex (nib),
        .seg (hex_seg)
    );

    assign blank_hi = BLANK_LZ && (cap[7:4] == 4'h0);

    // Capture register: unconditional load on every strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap   <= 8'h00;
            valid <= 1'b0;
        end else if (wr_en) begin
            cap   <= wr_data;
            valid <= 1'b1;
        end
    end

    // Scan FSM, refresh counter and registered display outputs. Outputs are
    // computed from the pre-edge state and capture register, so a write is
    // visible on seg two edges after it is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            seg   <= SEG_BLANK;
            an    <= AN_OFF;
        end else begin
            case (state)
                IDLE: begin
                    // IDLE only exists while valid=0, so any strobe here is
                    // the first capture; the counter is already at zero.
                    cnt <= '0;
                    if (wr_en) state <= DIG0;
                end
                DIG0: begin
                    cnt <= tc ? '0 : cnt + 1'b1;
                    if (tc) state <= DIG1;
                end
                DIG1: begin
                    cnt <= tc ? '0 : cnt + 1'b1;
                    if (tc) state <= DIG0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            case (state)
                DIG0: begin
                    an  <= AN_DIG0;
                    seg <= hex_seg;
                end
                DIG1: begin
                    // Leading-zero blank keeps the slot timing, just dark.
                    an  <= blank_hi ? AN_OFF    : AN_DIG1;
                    seg <= blank_hi ? SEG_BLANK : hex_seg;
                end
                default: begin
                    an  <= AN_OFF;
                    seg <= SEG_BLANK;
                end
            endcase
        end
    end

endmodule

// File: doc/display_mux_ctrl.md
DISPLAY_MUX_CTRL -- requirements
Module: display_mux_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles each digit is held during scanning; legal range 2..2^20.
REQ-002 Parameter BLANK_LZ, default 1; when 1, a leading zero in the high digit is blanked.
REQ-003 CLK  input  1  single system clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-low.
REQ-005 WR_EN  input  1  capture strobe from the processor's register write-back path.
REQ-006 WR_DATA  input  8  value to display; sampled when WR_EN=1.
REQ-007 SEG  output  7  shared segment bus, active-low; bit6=g ... bit0=a.
REQ-008 AN  output  2  digit enables, active-low; AN[0]=low nibble, AN[1]=high nibble.
REQ-009 VALID  output  1  high once any value has been captured since reset.

Function
REQ-010 Capture register SHALL load WR_DATA on every rising CLK edge where WR_EN=1, with no other conditions.
REQ-011 VALID SHALL rise on the edge after the first capture and stay high until reset.
REQ-012 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; the terminal count (TC) is the cycle in which the counter equals REFRESH_DIV-1.
REQ-013 FSM states SHALL be IDLE, DIG0 and DIG1.
REQ-014 IDLE SHALL go to DIG0 on the edge that sets VALID, and the counter SHALL clear to 0 on that same edge.
REQ-015 DIG0 SHALL go to DIG1 on TC.
REQ-016 DIG1 SHALL go to DIG0 on TC.
REQ-017 No other FSM transitions SHALL exist except reset.
REQ-018 While the FSM is in IDLE the counter SHALL be held at 0.
REQ-019 SEG and AN SHALL be registered outputs, reflecting the current state and capture register with one cycle of latency.
REQ-020 In IDLE: AN=2'b11 and SEG=7'h7F (all segments off).
REQ-021 In DIG0: AN=2'b10 and SEG=hex(low nibble).
REQ-022 In DIG1: AN=2'b01 and SEG=hex(high nibble).
REQ-023 Leading-zero blank: in DIG1, when BLANK_LZ=1 and the high nibble is 0, AN SHALL be 2'b11 and SEG SHALL be 7'h7F; the digit timing is unchanged.
REQ-024 Hex encoding table (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-025 A WR_EN in any state SHALL change the displayed digit on SEG exactly 2 edges after the capture edge: one edge to capture, one edge to the output register.
REQ-026 Scanning SHALL NOT be restarted or re-phased by a WR_EN.
REQ-027 WR_EN held high on consecutive cycles SHALL mean the last value captured wins.
REQ-028 A WR_EN that coincides with TC SHALL update the capture register and advance the FSM on the same edge.
REQ-029 AN SHALL never have both bits low in any cycle.

Reset
REQ-030 While RST=0, all registers SHALL be cleared immediately, independent of CLK.
REQ-031 Reset values: capture register=8'h00, VALID=0, counter=0, FSM=IDLE, SEG=7'h7F, AN=2'b11.
REQ-032 Release of reset SHALL be followed by normal operation on the next rising edge.
REQ-033 Reset asserted mid-scan SHALL blank the display immediately; scanning SHALL resume only after a new capture.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding constants (IDLE=2'd0, DIG0=2'd1, DIG1=2'd2).
REQ-035 The same package SHALL hold the 16-entry hex-to-segment constant table and the blank constant 7'h7F.
REQ-036 A single combinational sub-module, hex_to_seg7 (4-bit in, 7-bit out), SHALL implement the table.
REQ-037 hex_to_seg7 SHALL be instantiated once, driven by a nibble select taken from the FSM state.

Verification
REQ-038 The bench SHALL use REFRESH_DIV=4 and BLANK_LZ=1 unless a scenario states otherwise.
REQ-039 Reset then 20 idle cycles -> AN=11, SEG=7F and VALID=0 throughout.
REQ-040 WR_DATA=8'h3A pulsed for 1 cycle -> VALID=1, then AN=10/SEG=08 for 4 cycles, then AN=01/SEG=30 for 4 cycles, repeating.
REQ-041 WR_DATA=8'h05 with BLANK_LZ=1 -> DIG0 shows SEG=12; the DIG1 window shows AN=11/SEG=7F.
REQ-042 Same 8'h05 with BLANK_LZ=0 -> the DIG1 window shows AN=01/SEG=40.
REQ-043 During DIG0, write 8'hF1 at counter=1 -> SEG becomes 79 two edges later; the DIG0 window still ends at the original TC.
REQ-044 Assert RST for 3 ns mid-DIG1 with no clock edge -> AN=11 and SEG=7F within the reset window; after release, IDLE persists until the next WR_EN.
REQ-045 A bench assertion SHALL check in every cycle that AN is never 2'b00.
